// File: rtl/reg_transfer_ctrl.sv
// Sequencer for a shared-bus register-transfer datapath. It accepts one command at a time
// and emits one bus transfer per clock as a bus source select plus one-hot load enables.
module reg_transfer_ctrl #(
  parameter bit SWAP_EN = 1'b1
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic [1:0] Op,
  input  logic [1:0] SrcA,
  input  logic [1:0] DstB,
  output logic [2:0] Sel,
  output logic [4:0] Load,
  output logic       Busy,
  output logic       Done,
  output logic       Err
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_X1   = 3'd1,
    ST_X2   = 3'd2,
    ST_X3   = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [1:0] OP_MOVE  = 2'b00;
  localparam logic [1:0] OP_LOADX = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;

  localparam logic [2:0] SEL_EXT = 3'd4;
  localparam logic [2:0] SEL_T   = 3'd5;
  localparam int         LOAD_T  = 4;

  state_t     r_state;
  logic [1:0] r_op;
  logic [1:0] r_a;
  logic [1:0] r_b;

  logic       w_in_illegal;
  logic       w_in_noop;
  logic       w_op_illegal;
  logic [2:0] w_sel;
  logic [4:0] w_load;

  function automatic logic is_illegal(input logic [1:0] op);
    return (op == 2'b11) || ((op == OP_SWAP) && !SWAP_EN);
  endfunction

  // Commands that move no data skip the transfer states entirely.
  assign w_in_illegal = is_illegal(Op);
  assign w_in_noop    = (Op == OP_SWAP) && (SrcA == DstB);
  assign w_op_illegal = is_illegal(r_op);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_op    <= 2'b00;
      r_a     <= 2'b00;
      r_b     <= 2'b00;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (CmdValid) begin
            r_op    <= Op;
            r_a     <= SrcA;
            r_b     <= DstB;
            r_state <= (w_in_illegal || w_in_noop) ? ST_DONE : ST_X1;
          end
        end
        ST_X1:   r_state <= (r_op == OP_SWAP) ? ST_X2 : ST_DONE;
        ST_X2:   r_state <= ST_X3;
        ST_X3:   r_state <= ST_DONE;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    w_sel  = 3'd0;
    w_load = 5'b00000;
    unique case (r_state)
      ST_X1: begin
        if (r_op == OP_SWAP) begin
          w_sel          = {1'b0, r_a};
          w_load[LOAD_T] = 1'b1;
        end else begin
          w_sel       = (r_op == OP_LOADX) ? SEL_EXT : {1'b0, r_a};
          w_load[r_b] = 1'b1;
        end
      end
      ST_X2: begin
        w_sel       = {1'b0, r_b};
        w_load[r_a] = 1'b1;
      end
      ST_X3: begin
        w_sel       = SEL_T;
        w_load[r_b] = 1'b1;
      end
      default: ;
    endcase
  end

  // Load is gated by Reset so an aborted sequence never completes a transfer on the reset edge.
  assign Sel      = w_sel;
  assign Load     = Reset ? 5'b00000 : w_load;
  assign Busy     = (r_state != ST_IDLE);
  assign Done     = (r_state == ST_DONE);
  assign Err      = (r_state == ST_DONE) && w_op_illegal;
  assign CmdReady = (r_state == ST_IDLE) && !Reset;

  logic w_unused;
  assign w_unused = ^{OP_MOVE};

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// Self-checking bench for reg_transfer_ctrl: a bench-owned 5-register datapath follows Sel/Load,
// and results are compared against a command-level model of what each transfer should achieve.
module tb_reg_transfer_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_valid2;
  logic [1:0] op, src_a, dst_b;
  logic [2:0] ext;

  logic       ready, busy, done, err;
  logic [2:0] sel;
  logic [4:0] load;
  logic       ready2, busy2, done2, err2;
  logic [2:0] sel2;
  logic [4:0] load2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reg_transfer_ctrl #(.SWAP_EN(1'b1)) dut (
    .CLK(clk), .Reset(rst), .CmdValid(cmd_valid), .CmdReady(ready),
    .Op(op), .SrcA(src_a), .DstB(dst_b), .Sel(sel), .Load(load),
    .Busy(busy), .Done(done), .Err(err)
  );

  reg_transfer_ctrl #(.SWAP_EN(1'b0)) dut_noswap (
    .CLK(clk), .Reset(rst), .CmdValid(cmd_valid2), .CmdReady(ready2),
    .Op(op), .SrcA(src_a), .DstB(dst_b), .Sel(sel2), .Load(load2),
    .Busy(busy2), .Done(done2), .Err(err2)
  );

  // Bench datapath: R0..R3 and T (index 4), loaded from the Sel-muxed bus.
  logic [2:0] dp [5];
  logic       dp_clr;
  logic [2:0] bus;

  always_comb begin
    if (sel < 3'd4)       bus = dp[sel[1:0]];
    else if (sel == 3'd4) bus = ext;
    else                  bus = dp[4];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (dp_clr)       dp[i] <= 3'b000;
      else if (load[i]) dp[i] <= bus;
    end
  end

  // Expected register contents at command granularity.
  logic [2:0] m [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 5; i++) check($sformatf("%s_reg%0d", tag, i), dp[i], m[i]);
  endtask

  // Issue one command at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic run_cmd(input logic [1:0] c_op, input logic [1:0] c_a, input logic [1:0] c_b,
                         input logic [2:0] c_ext, input int exp_lat, input bit exp_err,
                         input string tag);
    logic [2:0] s_sel [3];
    logic [4:0] s_ld  [3];
    int         n;
    logic [2:0] tmp;
    bit         seen_done;

    n = 0;
    if (c_op == 2'b00) begin
      s_sel[0] = {1'b0, c_a}; s_ld[0] = 5'b1 << c_b; n = 1;
    end else if (c_op == 2'b01) begin
      s_sel[0] = 3'd4; s_ld[0] = 5'b1 << c_b; n = 1;
    end else if (c_op == 2'b10 && c_a != c_b) begin
      s_sel[0] = {1'b0, c_a}; s_ld[0] = 5'b10000;
      s_sel[1] = {1'b0, c_b}; s_ld[1] = 5'b1 << c_a;
      s_sel[2] = 3'd5;        s_ld[2] = 5'b1 << c_b;
      n = 3;
    end

    check({tag, "_ready_before"}, ready, 1'b1);
    op = c_op; src_a = c_a; dst_b = c_b; ext = c_ext; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble the command fields and keep CmdValid high: the controller must ignore both.
    op = 2'($urandom); src_a = 2'($urandom); dst_b = 2'($urandom);

    seen_done = 1'b0;
    for (int k = 0; k < 6 && !seen_done; k++) begin
      @(negedge clk);
      if (k < exp_lat) begin
        check($sformatf("%s_done_early%0d", tag, k), done, 1'b0);
        check($sformatf("%s_busy%0d", tag, k), busy, 1'b1);
        check($sformatf("%s_ready_busy%0d", tag, k), ready, 1'b0);
        if (k < n) begin
          check($sformatf("%s_sel%0d", tag, k), sel, s_sel[k]);
          check($sformatf("%s_load%0d", tag, k), load, s_ld[k]);
        end
      end else begin
        seen_done = 1'b1;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_err"}, err, exp_err);
        check({tag, "_done_load"}, load, 5'b00000);
        check({tag, "_done_sel"}, sel, 3'd0);
        check({tag, "_done_busy"}, busy, 1'b1);
        check({tag, "_done_ready"}, ready, 1'b0);
        cmd_valid = 1'b0;
        ext = ~c_ext;
      end
    end
    if (!seen_done) check({tag, "_done_timeout"}, 1'b0, 1'b1);

    unique case (c_op)
      2'b00: m[c_b] = m[c_a];
      2'b01: m[c_b] = c_ext;
      2'b10: if (c_a != c_b) begin
        tmp = m[c_a]; m[4] = tmp; m[c_a] = m[c_b]; m[c_b] = tmp;
      end
      default: ;
    endcase

    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_done"}, done, 1'b0);
    check({tag, "_idle_ready"}, ready, 1'b1);
    check({tag, "_idle_load"}, load, 5'b00000);
    check_regs(tag);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] ext;
    int         lat;
    bit         err;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r_op, r_a, r_b;
    logic [2:0] r_ext;
    int         lat;
    logic [2:0] t_before;

    vecs[0] = '{2'b01, 2'd0, 2'd0, 3'b110, 1, 1'b0};
    vecs[1] = '{2'b01, 2'd0, 2'd1, 3'b101, 1, 1'b0};
    vecs[2] = '{2'b01, 2'd2, 2'd3, 3'b011, 1, 1'b0};
    vecs[3] = '{2'b00, 2'd1, 2'd2, 3'b000, 1, 1'b0};
    vecs[4] = '{2'b01, 2'd0, 2'd3, 3'b001, 1, 1'b0};
    vecs[5] = '{2'b10, 2'd0, 2'd3, 3'b000, 3, 1'b0};
    vecs[6] = '{2'b10, 2'd2, 2'd2, 3'b000, 0, 1'b0};
    vecs[7] = '{2'b11, 2'd1, 2'd0, 3'b000, 0, 1'b1};
    vecs[8] = '{2'b00, 2'd2, 2'd2, 3'b000, 1, 1'b0};
    vecs[9] = '{2'b10, 2'd3, 2'd0, 3'b000, 3, 1'b0};

    for (int i = 0; i < 5; i++) m[i] = 3'b000;
    rst = 1'b1; dp_clr = 1'b1; cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    op = 2'b00; src_a = 2'd0; dst_b = 2'd0; ext = 3'd0;

    repeat (2) begin
      @(negedge clk);
      check("rst_load", load, 5'b00000);
      check("rst_ready", ready, 1'b0);
    end
    rst = 1'b0; dp_clr = 1'b0;
    #1;
    check("post_rst_sel", sel, 3'd0);
    check("post_rst_load", load, 5'b00000);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_done", done, 1'b0);
    check("post_rst_err", err, 1'b0);
    check("post_rst_ready", ready, 1'b1);
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ext, vecs[i].lat, vecs[i].err,
              $sformatf("vec%0d", i));

    // Reset while a SWAP sits in X2: the X2 load must be suppressed, T keeps the X1 value.
    t_before = m[1];
    op = 2'b10; src_a = 2'd1; dst_b = 2'd2; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rs_x1_load", load, 5'b10000);
    @(negedge clk);
    check("rs_x2_sel", sel, 3'd2);
    check("rs_x2_load_pre", load, 5'b00010);
    rst = 1'b1;
    #1;
    check("rs_x2_load_gated", load, 5'b00000);
    check("rs_x2_ready", ready, 1'b0);
    @(negedge clk);
    check("rs_after_busy", busy, 1'b0);
    check("rs_after_done", done, 1'b0);
    check("rs_after_load", load, 5'b00000);
    rst = 1'b0; cmd_valid = 1'b0;
    #1;
    check("rs_after_ready", ready, 1'b1);
    m[4] = t_before;
    check_regs("rs");
    @(negedge clk);

    // SWAP_EN=0 instance: SWAP is illegal, Done and Err together next cycle, no load.
    op = 2'b10; src_a = 2'd0; dst_b = 2'd1; cmd_valid2 = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid2 = 1'b0;
    @(negedge clk);
    check("ns_done", done2, 1'b1);
    check("ns_err", err2, 1'b1);
    check("ns_load", load2, 5'b00000);
    check("ns_main_idle", busy, 1'b0);
    @(negedge clk);
    check("ns_idle_ready", ready2, 1'b1);
    check("ns_idle_done", done2, 1'b0);
    op = 2'b00; src_a = 2'd3; dst_b = 2'd1; cmd_valid2 = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid2 = 1'b0;
    @(negedge clk);
    check("ns_move_sel", sel2, 3'd3);
    check("ns_move_load", load2, 5'b00010);
    @(negedge clk);
    check("ns_move_done", done2, 1'b1);
    check("ns_move_err", err2, 1'b0);
    @(negedge clk);

    // Randomized commands against the command-level model.
    for (int i = 0; i < 60; i++) begin
      r_op  = 2'($urandom);
      r_a   = 2'($urandom);
      r_b   = 2'($urandom);
      r_ext = 3'($urandom);
      if (r_op == 2'b11)                        lat = 0;
      else if (r_op == 2'b10 && r_a == r_b)     lat = 0;
      else if (r_op == 2'b10)                   lat = 3;
      else                                      lat = 1;
      run_cmd(r_op, r_a, r_b, r_ext, lat, r_op == 2'b11, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
